mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-ported instruction/data memory between the fetch stage (instruction reads) and the load/store stage (data reads and writes). It sits between the pipeline stages and the memory model. Each cycle it issues at most one access and routes the one-cycle-latency read data back to the requester that owns it. Load/store has fixed priority, and a starvation counter guarantees fetch forward progress.

---
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch (IF)
// and load/store (LS). Load/store has fixed priority. A saturating starvation
// counter forces a fetch grant after STARVE_LIMIT consecutive denied cycles.
// The memory has no backpressure and a fixed one-cycle read latency. A tag
// register therefore remembers who owns the read data arriving next cycle.
//
// Handshake: a requester raises *_req_i and holds its address, write enable
// and write data stable. The access is consumed in any cycle where *_gnt_o is
// high, so the grant is combinational with zero latency. A request dropped
// before its grant is simply forgotten. Read data comes back one cycle after
// the grant, qualified only by *_rvalid_o. Writes never produce an rvalid.
module mem_arbiter #(
   parameter int DWIDTH       = 32,
   parameter int AWIDTH       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [AWIDTH-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DWIDTH-1:0] if_rdata_o,
   input  logic              ls_req_i,
   input  logic              ls_we_i,
   input  logic [AWIDTH-1:0] ls_addr_i,
   input  logic [DWIDTH-1:0] ls_wdata_i,
   output logic              ls_gnt_o,
   output logic              ls_rvalid_o,
   output logic [DWIDTH-1:0] ls_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [AWIDTH-1:0] mem_addr_o,
   output logic [DWIDTH-1:0] mem_wdata_o,
   input  logic [DWIDTH-1:0] mem_rdata_i
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_LS = 1'b1
   } owner_t;

   logic [3:0]  r_starve_cnt;
   logic        r_tag_valid;
   owner_t      r_tag_owner;

   logic        w_starved;
   logic        w_if_win;
   logic        w_ls_win;
   logic        w_mem_we;
   logic [AWIDTH-1:0] w_mem_addr;
   logic [DWIDTH-1:0] w_mem_wdata;

   // Grant decision: LS wins unless fetch is starved; nothing is granted in reset.
   always_comb begin
      w_starved = (r_starve_cnt == LIMIT);
      w_if_win  = ~rst & if_req_i & (~ls_req_i | w_starved);
      w_ls_win  = ~rst & ls_req_i & ~w_if_win;
   end

   // Memory request mux: the winner drives the bus, an idle cycle drives zeros.
   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      if (w_ls_win) begin
         w_mem_we    = ls_we_i;
         w_mem_addr  = ls_addr_i;
         w_mem_wdata = ls_wdata_i;
      end else if (w_if_win) begin
         w_mem_addr  = if_addr_i;
      end
   end

   assign if_gnt_o    = w_if_win;
   assign ls_gnt_o    = w_ls_win;
   assign mem_req_o   = w_if_win | w_ls_win;
   assign mem_we_o    = w_mem_we;
   assign mem_addr_o  = w_mem_addr;
   assign mem_wdata_o = w_mem_wdata;

   // Response tag: remembers whether next cycle's read data belongs to IF or LS.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tag_valid <= 1'b0;
         r_tag_owner <= OWNER_IF;
      end else begin
         r_tag_valid <= mem_req_o & ~mem_we_o;
         r_tag_owner <= w_ls_win ? OWNER_LS : OWNER_IF;
      end
   end

   // Starvation counter: counts consecutive denied fetch cycles, saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_starve_cnt <= 4'd0;
      end else if (if_req_i & ~if_gnt_o) begin
         if (r_starve_cnt != LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
         end
      end else begin
         r_starve_cnt <= 4'd0;
      end
   end

   assign if_rvalid_o = r_tag_valid & (r_tag_owner == OWNER_IF);
   assign ls_rvalid_o = r_tag_valid & (r_tag_owner == OWNER_LS);
   assign if_rdata_o  = mem_rdata_i;
   assign ls_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. A driver issues one request pattern per cycle and
// predicts grants and bus values from the arbitration rules. Expected read
// responses go into a queue that an independent monitor drains.
module tb_mem_arbiter;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int LIM = 4;

   logic          clk;
   logic          rst;
   logic          if_req_i;
   logic [AW-1:0] if_addr_i;
   logic          if_gnt_o;
   logic          if_rvalid_o;
   logic [DW-1:0] if_rdata_o;
   logic          ls_req_i;
   logic          ls_we_i;
   logic [AW-1:0] ls_addr_i;
   logic [DW-1:0] ls_wdata_i;
   logic          ls_gnt_o;
   logic          ls_rvalid_o;
   logic [DW-1:0] ls_rdata_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i;

   mem_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
      .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
      .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   // ---------------- clock / reset / cycle count ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] cyc = 16'd0;
   always @(posedge clk) cyc <= cyc + 16'd1;

   // ---------------- counters ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // ---------------- memory contents ----------------
   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // Environment memory seen by the DUT.
   logic [31:0] env_mem[logic [31:0]];
   // Bench's own reference copy, updated only from predicted grants.
   logic [31:0] ref_mem[logic [31:0]];

   function automatic logic [31:0] env_rd(input logic [31:0] a);
      return env_mem.exists(a) ? env_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   // Single-ported memory: writes commit at the edge, reads return one cycle later.
   always @(posedge clk) begin
      if (mem_req_o && mem_we_o) env_mem[mem_addr_o] = mem_wdata_o;
      if (mem_req_o && !mem_we_o) mem_rdata_i <= env_rd(mem_addr_o);
      else mem_rdata_i <= $urandom;
   end

   // ---------------- scoreboard ----------------
   // Entry: {due cycle[15:0], owner (0=IF,1=LS), data[31:0]}
   logic [48:0] exp_q[$];
   int streak = 0;    // consecutive cycles fetch asked and was refused
   logic act_if_gnt;

   // Monitor: every response must match the oldest outstanding read, on time.
   always @(negedge clk) begin
      logic [48:0] e;
      if (if_rvalid_o && ls_rvalid_o) chk("both_rvalid", 1, 0);
      while (exp_q.size() > 0 && exp_q[0][48:33] < cyc) begin
         e = exp_q.pop_front();
         chk("rvalid_missing", 0, 1);
      end
      if (if_rvalid_o || ls_rvalid_o) begin
         if (exp_q.size() == 0) begin
            chk("rvalid_unexpected", {ls_rvalid_o, if_rvalid_o}, 0);
         end else begin
            e = exp_q.pop_front();
            chk("rvalid_cycle", cyc, e[48:33]);
            chk("rvalid_owner", ls_rvalid_o, e[32]);
            chk("rdata", ls_rvalid_o ? ls_rdata_o : if_rdata_o, e[31:0]);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic step(input logic ir, input logic [31:0] ia,
                       input logic lr, input logic lw,
                       input logic [31:0] la, input logic [31:0] lwd);
      logic ei, el;
      @(negedge clk);
      if_req_i = ir; if_addr_i = ia;
      ls_req_i = lr; ls_we_i = lw; ls_addr_i = la; ls_wdata_i = lwd;
      #1;
      ei = ir && (!lr || streak >= LIM);
      el = lr && !ei;
      act_if_gnt = if_gnt_o;
      chk("if_gnt", if_gnt_o, ei);
      chk("ls_gnt", ls_gnt_o, el);
      chk("mem_req", mem_req_o, ei || el);
      if (el) begin
         chk("mem_addr_ls", mem_addr_o, la);
         chk("mem_we_ls", mem_we_o, lw);
         if (lw) chk("mem_wdata", mem_wdata_o, lwd);
      end else if (ei) begin
         chk("mem_addr_if", mem_addr_o, ia);
         chk("mem_we_if", mem_we_o, 0);
      end else begin
         chk("idle_bus", {mem_we_o, mem_addr_o, mem_wdata_o}, 0);
      end
      if (ei) exp_q.push_back({cyc + 16'd1, 1'b0, ref_rd(ia)});
      if (el && !lw) exp_q.push_back({cyc + 16'd1, 1'b1, ref_rd(la)});
      if (el && lw) ref_mem[la] = lwd;
      if (ir && !ei) streak = (streak < LIM) ? streak + 1 : LIM;
      else streak = 0;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst = 1'b1;
      if_req_i = 0; if_addr_i = 0; ls_req_i = 0; ls_we_i = 0;
      ls_addr_i = 0; ls_wdata_i = 0;

      // Reset with both requests asserted: everything blocked.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if_req_i = 1; if_addr_i = 32'h0100_0000;
         ls_req_i = 1; ls_addr_i = 32'h100;
         #1;
         chk("rst_if_gnt", if_gnt_o, 0);
         chk("rst_ls_gnt", ls_gnt_o, 0);
         chk("rst_mem_req", mem_req_o, 0);
         chk("rst_rvalid", {if_rvalid_o, ls_rvalid_o}, 0);
      end
      @(negedge clk);
      rst = 1'b0; if_req_i = 0; ls_req_i = 0;
      streak = 0;

      // First fetch after reset, then back-to-back fetches.
      step(1, 32'h0100_0000, 0, 0, 0, 0);
      step(1, 32'h0100_0000, 0, 0, 0, 0);
      step(1, 32'h0100_0004, 0, 0, 0, 0);
      step(1, 32'h0100_0008, 0, 0, 0, 0);
      idle();

      // LS priority over fetch.
      step(1, 32'h0100_0000, 1, 0, 32'h100, 32'h0);
      idle();

      // Starvation: both held; fetch wins every fifth cycle.
      for (int i = 0; i < 10; i++) begin
         step(1, 32'h0100_0000 + 32'(4 * i), 1, 0, 32'h100 + 32'(4 * i), 0);
         chk("starve_pattern", act_if_gnt, (i % 5) == 4);
      end
      idle();

      // Write then read back.
      step(0, 0, 1, 1, 32'h200, 32'hDEAD_BEEF);
      step(0, 0, 1, 0, 32'h200, 0);
      idle();
      chk("write_readback_model", ref_rd(32'h200), 32'hDEAD_BEEF);

      // Reset while a fetch response is in flight.
      step(1, 32'h0100_0010, 0, 0, 0, 0);
      @(posedge clk);
      #2;
      chk("rvalid_before_rst", if_rvalid_o, 1);
      rst = 1'b1;
      #1;
      chk("rvalid_dropped", if_rvalid_o, 0);
      exp_q.delete();
      streak = 0;
      @(negedge clk);
      if_req_i = 0; ls_req_i = 0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rvalid_after_release", {if_rvalid_o, ls_rvalid_o}, 0);
      idle();
      idle();

      // Randomized traffic over a small address pool so writes and reads collide.
      for (int i = 0; i < 400; i++) begin
         logic ir, lr, lw;
         logic [31:0] ia, la;
         ir = ($urandom_range(0, 99) < 65);
         lr = ($urandom_range(0, 99) < 70);
         lw = ($urandom_range(0, 2) == 0);
         ia = 32'h0100_0000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
         la = 32'h0000_0200 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
         step(ir, ia, lr, lw, la, $urandom);
      end

      idle();
      idle();
      idle();
      chk("queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
